entrada_switch_ctrl: RTL and testbench

Front end for the `Entrada` input stack. It synchronizes and debounces the two push buttons and the 16 data switches, and turns each accepted button press into a single-cycle `switchRead` (push) or `switchWrite` (pop) pulse. It keeps a shadow occupancy count so it never pushes into a full stack or pops an empty one. It sits between the board pins and `Entrada`, and its outputs drive `Entrada`'s `_input`, `switchRead` and `switchWrite` directly.

---
 rtl/entrada_switch_ctrl.sv | 142 ++++++++++++++
 tb/tb_entrada_switch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/entrada_switch_ctrl.sv
// Button/switch front end for the Entrada stack: 2-flop sync, debounce, push/pop strobes, occupancy shadow.
// Optional sticky error flag port `err` is built when ENTRADA_ERR_FLAG_EN is defined.
module entrada_switch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned DEPTH           = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_read_raw,
    input  logic        btn_write_raw,
    input  logic [15:0] sw_raw,
    output logic [15:0] _input,
    output logic        switchRead,
    output logic        switchWrite,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty
`ifdef ENTRADA_ERR_FLAG_EN
    ,
    output logic        err
`endif
);

    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]  DEPTH_VAL = 4'(DEPTH);

    // Bit 0 is the push (read) button, bit 1 the pop (write) button.
    logic [1:0]       btn_meta_r;
    logic [1:0]       btn_sync_r;
    logic [15:0]      sw_meta_r;
    logic [15:0]      sw_sync_r;
    logic [1:0]       stable_r;
    logic [1:0]       stable_d_r;
    logic [1:0]       req_r;
    logic [1:0][15:0] cnt_r;
    logic             rd_go_s;
    logic             wr_go_s;
    logic [3:0]       count_nxt_s;

    // Two-flop synchronizers for buttons and switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_r <= 2'b00;
            btn_sync_r <= 2'b00;
            sw_meta_r  <= 16'h0000;
            sw_sync_r  <= 16'h0000;
        end else begin
            btn_meta_r <= {btn_write_raw, btn_read_raw};
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= sw_raw;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Debounce each button and register a one-cycle request on an accepted rising level.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_r   <= 2'b00;
            stable_d_r <= 2'b00;
            req_r      <= 2'b00;
            cnt_r      <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_sync_r[i] == stable_r[i]) begin
                    cnt_r[i] <= 16'd0;
                end else if (cnt_r[i] == DB_LAST) begin
                    stable_r[i] <= btn_sync_r[i];
                    cnt_r[i]    <= 16'd0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + 16'd1;
                end
            end
            stable_d_r <= stable_r;
            req_r      <= stable_r & ~stable_d_r;
        end
    end

    // Arbitrate requests against occupancy; simultaneous requests cancel each other.
    always_comb begin
        rd_go_s     = 1'b0;
        wr_go_s     = 1'b0;
        count_nxt_s = count;
        case (req_r)
            2'b01: begin
                if (!full) begin
                    rd_go_s     = 1'b1;
                    count_nxt_s = count + 4'd1;
                end else begin
                    rd_go_s = 1'b0;
                end
            end
            2'b10: begin
                if (!empty) begin
                    wr_go_s     = 1'b1;
                    count_nxt_s = count - 4'd1;
                end else begin
                    wr_go_s = 1'b0;
                end
            end
            default: begin
                rd_go_s = 1'b0;
                wr_go_s = 1'b0;
            end
        endcase
    end

    // Registered strobes, switch snapshot and occupancy flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            _input      <= 16'h0000;
            switchRead  <= 1'b0;
            switchWrite <= 1'b0;
            count       <= 4'd0;
            full        <= 1'b0;
            empty       <= 1'b1;
        end else begin
            switchRead  <= rd_go_s;
            switchWrite <= wr_go_s;
            count       <= count_nxt_s;
            full        <= (count_nxt_s == DEPTH_VAL);
            empty       <= (count_nxt_s == 4'd0);
            if (rd_go_s) begin
                _input <= sw_sync_r;
            end
        end
    end

`ifdef ENTRADA_ERR_FLAG_EN
    logic drop_s;
    assign drop_s = (req_r[0] & req_r[1]) | (req_r[0] & full) | (req_r[1] & empty);

    // Sticky flag for any request that was dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (drop_s) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_entrada_switch_ctrl.sv
// Randomized self-checking bench for entrada_switch_ctrl with DEBOUNCE_CYCLES=4,
// checked against a press-level occupancy model.
module tb_entrada_switch_ctrl;

    localparam int DB    = 4;
    localparam int DEPTH = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_read_raw;
    logic        btn_write_raw;
    logic [15:0] sw_raw;
    logic [15:0] _input;
    logic        switchRead;
    logic        switchWrite;
    logic [3:0]  count;
    logic        full;
    logic        empty;
`ifdef ENTRADA_ERR_FLAG_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    entrada_switch_ctrl #(.DEBOUNCE_CYCLES(DB), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_read_raw (btn_read_raw),
        .btn_write_raw(btn_write_raw),
        .sw_raw       (sw_raw),
        ._input       (_input),
        .switchRead   (switchRead),
        .switchWrite  (switchWrite),
        .count        (count),
        .full         (full),
        .empty        (empty)
`ifdef ENTRADA_ERR_FLAG_EN
        ,
        .err          (err)
`endif
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    int          m_count;
    logic [15:0] m_input;
    bit          m_err;
    int          rd_seen;
    int          wr_seen;
    int          overlap;
    int          first_k;
    int          cnt_at_strobe;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_monitor();
        rd_seen       = 0;
        wr_seen       = 0;
        overlap       = 0;
        first_k       = -1;
        cnt_at_strobe = -1;
    endtask

    task automatic watch(input int cycles, input int base);
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (switchRead && switchWrite) overlap++;
            if (switchRead || switchWrite) begin
                if (first_k < 0) begin
                    first_k       = base + c;
                    cnt_at_strobe = int'(count);
                end
            end
            if (switchRead) rd_seen++;
            if (switchWrite) wr_seen++;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".full"}, 32'(full), 32'(m_count == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
        chk({tag, "._input"}, 32'(_input), 32'(m_input));
`ifdef ENTRADA_ERR_FLAG_EN
        chk({tag, ".err"}, 32'(err), 32'(m_err));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        btn_read_raw  = 1'b0;
        btn_write_raw = 1'b0;
        repeat (2) @(negedge clk);
        m_count = 0;
        m_input = 16'h0000;
        m_err   = 1'b0;
        chk("rst.switchRead", 32'(switchRead), 32'd0);
        chk("rst.switchWrite", 32'(switchWrite), 32'd0);
        check_state("rst");
        reset = 1'b0;
    endtask

    // One full press/hold/release of the selected buttons, then compare against the model.
    task automatic press(input string tag, input bit rd, input bit wr, input logic [15:0] sw);
        int exp_rd;
        int exp_wr;
        clear_monitor();
        @(negedge clk);
        sw_raw        = sw;
        btn_read_raw  = rd;
        btn_write_raw = wr;
        watch(DB + 8, 0);
        btn_read_raw  = 1'b0;
        btn_write_raw = 1'b0;
        watch(DB + 6, DB + 8);
        exp_rd = 0;
        exp_wr = 0;
        if (rd && wr) begin
            m_err = 1'b1;
        end else if (rd) begin
            if (m_count < DEPTH) begin
                exp_rd = 1;
                m_count++;
                m_input = sw;
            end else begin
                m_err = 1'b1;
            end
        end else if (wr) begin
            if (m_count > 0) begin
                exp_wr = 1;
                m_count--;
            end else begin
                m_err = 1'b1;
            end
        end
        chk({tag, ".rd_strobes"}, 32'(rd_seen), 32'(exp_rd));
        chk({tag, ".wr_strobes"}, 32'(wr_seen), 32'(exp_wr));
        chk({tag, ".overlap"}, 32'(overlap), 32'd0);
        if (exp_rd + exp_wr > 0) begin
            chk({tag, ".latency"}, 32'(first_k), 32'(DB + 4));
            chk({tag, ".count_at_strobe"}, 32'(cnt_at_strobe), 32'(m_count));
        end
        check_state(tag);
    endtask

    task automatic bounce(input string tag);
        logic [4:0] pat;
        pat = 5'b10101;
        clear_monitor();
        @(negedge clk);
        sw_raw = 16'($urandom);
        for (int i = 0; i < 5; i++) begin
            btn_read_raw = pat[i];
            watch(1, i);
        end
        btn_read_raw = 1'b0;
        watch(DB + 8, 5);
        chk({tag, ".rd_strobes"}, 32'(rd_seen), 32'd0);
        chk({tag, ".wr_strobes"}, 32'(wr_seen), 32'd0);
        check_state(tag);
    endtask

    initial begin
        int r;
        reset         = 1'b1;
        btn_read_raw  = 1'b0;
        btn_write_raw = 1'b0;
        sw_raw        = 16'h0000;
        m_count       = 0;
        m_input       = 16'h0000;
        m_err         = 1'b0;

        do_reset();
        press("push_a5c3", 1'b1, 1'b0, 16'hA5C3);
        bounce("bounce");

        for (int i = 0; i < 14; i++) press("fill", 1'b1, 1'b0, 16'($urandom));
        press("push_full", 1'b1, 1'b0, 16'($urandom));

        do_reset();
        press("pre_pop1", 1'b1, 1'b0, 16'h1234);
        press("pre_pop2", 1'b1, 1'b0, 16'h8001);
        press("pop1", 1'b0, 1'b1, 16'($urandom));
        press("pop2", 1'b0, 1'b1, 16'($urandom));
        press("pop_empty", 1'b0, 1'b1, 16'($urandom));

        do_reset();
        press("pre_both", 1'b1, 1'b0, 16'h00FF);
        press("both", 1'b1, 1'b1, 16'hFF00);

        // Reset lands two cycles into a debounce while the button stays held.
        clear_monitor();
        @(negedge clk);
        sw_raw       = 16'h3C5A;
        btn_read_raw = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        m_count = 0;
        m_input = 16'h0000;
        m_err   = 1'b0;
        chk("mid_rst.switchRead", 32'(switchRead), 32'd0);
        check_state("mid_rst");
        reset = 1'b0;
        watch(DB + 8, 0);
        btn_read_raw = 1'b0;
        watch(DB + 6, DB + 8);
        m_count = 1;
        m_input = 16'h3C5A;
        chk("held_rst.rd_strobes", 32'(rd_seen), 32'd1);
        chk("held_rst.latency", 32'(first_k), 32'(DB + 4));
        check_state("held_rst");

        do_reset();
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 4) press("rnd_push", 1'b1, 1'b0, 16'($urandom));
            else if (r <= 7) press("rnd_pop", 1'b0, 1'b1, 16'($urandom));
            else if (r == 8) press("rnd_both", 1'b1, 1'b1, 16'($urandom));
            else bounce("rnd_bounce");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
